// File: rtl/bit_akis_pkg.sv
// Shared types and constants for the framed bit-stream transmitter/receivers.
package bit_akis_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } bit_akis_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Cycles of o_valid per frame: start + data + parity + stop, each BIT_CYCLES long.
  function automatic int frame_len(input int data_w, input int bit_cycles);
    return (data_w + 3) * bit_cycles;
  endfunction

endpackage

// File: rtl/bit_akis_zamanlayici.sv
// Per-bit tick generator: counts 0..BIT_CYCLES-1 while enabled and flags the last cycle.
module bit_akis_zamanlayici #(
  parameter int BIT_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_bit_end
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // bit_end is combinational so the owner can act on the same edge that wraps the counter
  assign o_bit_end = i_en && (r_cnt == LAST);

  // Cycle counter, wraps at the end of each bit period
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)          r_cnt <= '0;
    else if (i_clr)     r_cnt <= '0;
    else if (i_en)      r_cnt <= o_bit_end ? '0 : r_cnt + CW'(1);
  end

endmodule

// File: rtl/bit_akis_uretici.sv
// Framed serial transmitter: start, data MSB-first, parity, stop; each bit BIT_CYCLES long.
module bit_akis_uretici
  import bit_akis_pkg::*;
#(
  parameter int DATA_W      = 3,
  parameter int BIT_CYCLES  = 4,
  parameter int PARITY_EVEN = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_flag,
  input  logic              i_err_inj,
  output logic              o_bit,
  output logic              o_valid,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_drop
);

  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);
  // Extra XOR term that turns even parity into odd parity
  localparam logic ODD_TERM = (PARITY_EVEN == 0);

  bit_akis_state_e   r_state;
  logic [DATA_W-1:0] r_shift;
  logic [IW-1:0]     r_idx;
  logic              r_par;
  logic              w_bit_end;
  logic              w_idle;

  assign w_idle = (r_state == IDLE);

  bit_akis_zamanlayici #(.BIT_CYCLES(BIT_CYCLES)) u_zaman (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (w_idle),
    .i_en     (!w_idle),
    .o_bit_end(w_bit_end)
  );

  // Frame sequencer; every output is a register updated alongside the state
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_par   <= 1'b0;
      o_bit   <= IDLE_LEVEL;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_drop  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      // Any strobe outside IDLE (including the final stop cycle) is rejected
      o_drop <= i_flag && !w_idle;
      case (r_state)
        IDLE: begin
          if (i_flag) begin
            r_shift <= i_data;
            r_par   <= (^i_data) ^ ODD_TERM ^ i_err_inj;
            r_idx   <= '0;
            r_state <= START;
            o_bit   <= START_BIT;
            o_valid <= 1'b1;
            o_busy  <= 1'b1;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_state <= DATA;
            r_idx   <= '0;
            o_bit   <= r_shift[DATA_W-1];
            r_shift <= r_shift << 1;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            if (r_idx == LAST_IDX) begin
              r_state <= PARITY;
              o_bit   <= r_par;
            end else begin
              r_idx   <= r_idx + IW'(1);
              o_bit   <= r_shift[DATA_W-1];
              r_shift <= r_shift << 1;
            end
          end
        end
        PARITY: begin
          if (w_bit_end) begin
            r_state <= STOP;
            o_bit   <= STOP_BIT;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_state <= IDLE;
            o_bit   <= IDLE_LEVEL;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          o_bit   <= IDLE_LEVEL;
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_akis_uretici.sv
// Randomized + directed bench for bit_akis_uretici with a frame-position reference model.
module tb_bit_akis_uretici;
  import bit_akis_pkg::*;

  localparam int DW  = 3;
  localparam int BC  = 4;
  localparam int LEN = (DW + 3) * BC;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [DW-1:0] i_data = '0;
  logic          i_flag = 1'b0;
  logic          i_err_inj = 1'b0;

  logic e_bit, e_valid, e_busy, e_done, e_drop;
  logic o_bit_o, o_valid_o, o_busy_o, o_done_o, o_drop_o;

  int n_tests = 0;
  int n_fail  = 0;

  bit_akis_uretici #(.DATA_W(DW), .BIT_CYCLES(BC), .PARITY_EVEN(1)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_flag(i_flag), .i_err_inj(i_err_inj),
    .o_bit(e_bit), .o_valid(e_valid), .o_busy(e_busy), .o_done(e_done), .o_drop(e_drop)
  );

  bit_akis_uretici #(.DATA_W(DW), .BIT_CYCLES(BC), .PARITY_EVEN(0)) dut_odd (
    .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_flag(i_flag), .i_err_inj(i_err_inj),
    .o_bit(o_bit_o), .o_valid(o_valid_o), .o_busy(o_busy_o), .o_done(o_done_o), .o_drop(o_drop_o)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: position inside the current frame ----------------
  int   m_pos = -1;          // -1 = idle, else cycle index 0..LEN-1 within the frame
  logic m_bits [DW+3];       // frame bits for the even-parity instance
  logic m_done = 1'b0;
  logic m_drop = 1'b0;

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_pos  = -1;
      m_done = 1'b0;
      m_drop = 1'b0;
    end else begin
      m_done = (m_pos == LEN - 1);
      m_drop = i_flag && (m_pos >= 0);
      if (m_pos >= 0) begin
        m_pos++;
        if (m_pos == LEN) m_pos = -1;
      end else if (i_flag) begin
        m_bits[0] = 1'b0;
        for (int b = 0; b < DW; b++) m_bits[1 + b] = i_data[DW - 1 - b];
        m_bits[DW + 1] = (^i_data) ^ i_err_inj;
        m_bits[DW + 2] = 1'b1;
        m_pos = 0;
      end
      #1;
      if (!i_rst) begin
        logic xb, xo;
        xb = (m_pos >= 0) ? m_bits[m_pos / BC] : 1'b1;
        xo = ((m_pos >= 0) && (m_pos / BC == DW + 1)) ? ~xb : xb;
        chk("bit_even",  {31'd0, e_bit},   {31'd0, xb});
        chk("bit_odd",   {31'd0, o_bit_o}, {31'd0, xo});
        chk("valid",     {30'd0, e_valid, o_valid_o}, {30'd0, {2{m_pos >= 0}}});
        chk("busy",      {30'd0, e_busy,  o_busy_o},  {30'd0, {2{m_pos >= 0}}});
        chk("done",      {30'd0, e_done,  o_done_o},  {30'd0, {2{m_done}}});
        chk("drop",      {30'd0, e_drop,  o_drop_o},  {30'd0, {2{m_drop}}});
      end
    end
  end

  // ---------------- directed helpers ----------------
  // Cycle 0 = acceptance cycle; cycle c is sampled mid-period; flag_mask[c] drives i_flag in cycle c.
  task automatic run_frame(input logic [DW-1:0] data, input logic err, input logic [31:0] flag_mask,
                           output logic [LEN-1:0] tr_e, output logic [LEN-1:0] tr_o,
                           output int done_cyc, output int vcnt, output int drops);
    @(negedge i_clk);
    i_data = data; i_err_inj = err; i_flag = 1'b1;
    tr_e = '0; tr_o = '0; done_cyc = -1; vcnt = 0; drops = 0;
    for (int c = 1; c <= 26; c++) begin
      @(negedge i_clk);
      if (c <= LEN) begin
        tr_e[LEN - c] = e_bit;
        tr_o[LEN - c] = o_bit_o;
      end
      if (c <= 25 && e_valid) vcnt++;
      if (e_done && done_cyc < 0) done_cyc = c;
      if (e_drop) drops++;
      i_flag = flag_mask[c];
      i_data = DW'($urandom);
      i_err_inj = 1'($urandom);
    end
    i_flag = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge i_clk);
      if (!e_busy && !e_done) break;
    end
    n_tests++;
    if (i == budget) begin
      n_fail++;
      $display("FAIL wait_idle: still busy after %0d cycles", budget);
    end
  endtask

  logic [LEN-1:0] tr_e, tr_o;
  int done_cyc, vcnt, drops;

  initial begin
    // reset state
    #12;
    chk("rst_bit",   {31'd0, e_bit},   32'd1);
    chk("rst_valid", {31'd0, e_valid}, 32'd0);
    chk("rst_busy",  {31'd0, e_busy},  32'd0);
    chk("rst_done",  {30'd0, e_done, e_drop}, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);

    // 3'b101: 0,1,0,1,0(par),1 x4
    run_frame(3'b101, 1'b0, 32'd0, tr_e, tr_o, done_cyc, vcnt, drops);
    chk("t101_trace", {8'd0, tr_e}, 32'h0F0F0F);
    chk("t101_done",  done_cyc, 25);
    chk("t101_valid", vcnt, 24);

    // 3'b111: even parity 1, odd parity 0
    run_frame(3'b111, 1'b0, 32'd0, tr_e, tr_o, done_cyc, vcnt, drops);
    chk("t111_even", {8'd0, tr_e}, 32'h0FFFFF);
    chk("t111_odd",  {8'd0, tr_o}, 32'h0FFF0F);

    // 3'b000 with injected error, then clean
    run_frame(3'b000, 1'b1, 32'd0, tr_e, tr_o, done_cyc, vcnt, drops);
    chk("t000_err", {8'd0, tr_e}, 32'h0000FF);
    run_frame(3'b000, 1'b0, 32'd0, tr_e, tr_o, done_cyc, vcnt, drops);
    chk("t000_ok",  {8'd0, tr_e}, 32'h00000F);

    // collisions at cycles 5, 23 and 24 (final stop cycle), then acceptance in the done cycle
    run_frame(3'b110, 1'b0, (32'd1 << 5) | (32'd1 << 23) | (32'd1 << 24) | (32'd1 << 25),
              tr_e, tr_o, done_cyc, vcnt, drops);
    chk("coll_trace", {8'd0, tr_e}, 32'h0FF00F);
    chk("coll_drops", drops, 3);
    chk("coll_done",  done_cyc, 25);
    chk("b2b_start",  {30'd0, e_bit, e_valid}, 32'd1);
    wait_idle(40);

    // reset mid-DATA
    @(negedge i_clk);
    i_data = 3'b111; i_flag = 1'b1;
    @(negedge i_clk);
    i_flag = 1'b0;
    repeat (9) @(negedge i_clk);
    @(posedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    chk("mid_rst_bit",   {30'd0, e_bit, o_bit_o}, 32'd3);
    chk("mid_rst_busy",  {30'd0, e_busy, e_valid}, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (30) begin
      @(negedge i_clk);
      chk("mid_rst_nodone", {31'd0, e_done}, 32'd0);
    end
    run_frame(3'b010, 1'b0, 32'd0, tr_e, tr_o, done_cyc, vcnt, drops);
    chk("t010_even", {8'd0, tr_e}, 32'h00F0FF);
    chk("t010_odd",  {8'd0, tr_o}, 32'h00F00F);

    // random frames; model checks every cycle
    for (int f = 0; f < 100; f++) begin
      int gap;
      @(negedge i_clk);
      i_data = DW'($urandom);
      i_err_inj = ($urandom_range(0, 3) == 0);
      i_flag = 1'b1;
      @(negedge i_clk);
      i_flag = 1'b0;
      gap = $urandom_range(1, 20);
      repeat (gap) @(negedge i_clk);
      if ($urandom_range(0, 2) == 0) begin
        i_flag = 1'b1;
        @(negedge i_clk);
        i_flag = 1'b0;
      end
      wait_idle(60);
      repeat ($urandom_range(0, 2)) @(negedge i_clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
